// File: rtl/pipeline_output_fifo_if.sv
// pipeline_output_fifo_if: push-side, ready/valid pop-side and status signals of the output FIFO.
interface pipeline_output_fifo_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    count;
  logic             almost_full;
  logic             overflow;
  modport master (
    output in_data, in_valid, out_ready,
    input  out_data, out_valid, count, almost_full, overflow
  );
  modport slave (
    input  in_data, in_valid, out_ready,
    output out_data, out_valid, count, almost_full, overflow
  );
endinterface

// File: rtl/pipeline_output_fifo.sv
// pipeline_output_fifo: elastic buffer that absorbs unstallable pipeline results and re-presents them ready/valid.
module pipeline_output_fifo #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 4,
  parameter int AFULL_LEVEL = 3
) (
  input logic clk,
  input logic rst,
  pipeline_output_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    cnt;
  logic             ovf, pop, push;
  assign pop  = (cnt != '0) && bus.out_ready;
  // a full buffer still accepts when the head leaves in the same cycle
  assign push = bus.in_valid && ((cnt != CW'(DEPTH)) || pop);
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.in_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push != pop) cnt <= push ? cnt + 1'b1 : cnt - 1'b1;
      if (bus.in_valid && !push) ovf <= 1'b1;
    end
  end
  assign bus.out_data    = mem[rd_ptr];
  assign bus.out_valid   = cnt != '0;
  assign bus.almost_full = cnt >= CW'(AFULL_LEVEL);
  assign bus.count       = cnt;
  assign bus.overflow    = ovf;
endmodule

// File: tb/tb_pipeline_output_fifo.sv
// tb_pipeline_output_fifo: vector table plus queue scoreboard for the pipeline output FIFO.
module tb_pipeline_output_fifo;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int AFL   = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] q[$];
  bit ovf_m = 1'b0;
  bit armed = 1'b0;
  bit pop_m;
  pipeline_output_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  pipeline_output_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_LEVEL(AFL)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  typedef struct {
    bit             v;
    logic [31:0]    d;
    bit             r;
    int             cnt;
    bit             ov;
    logic [31:0]    head;
    bit             af;
    bit             of;
  } vec_t;
  vec_t vecs[11];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cycle(input bit v, input logic [31:0] d, input bit r, input bit rr = 1'b0);
    rst = rr;
    bus.in_valid = v;
    bus.in_data = d;
    bus.out_ready = r;
    @(posedge clk);
    #1;
  endtask
  // scoreboard: at negedge, check post-edge state, then model the coming edge
  always @(negedge clk) begin
    if (armed) begin
      chk("sb_count", 32'(bus.count), 32'(q.size()));
      chk("sb_out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
      chk("sb_almost_full", 32'(bus.almost_full), 32'(q.size() >= AFL));
      chk("sb_overflow", 32'(bus.overflow), 32'(ovf_m));
    end
    if (rst) begin
      q.delete();
      ovf_m = 1'b0;
      armed = 1'b1;
    end else if (armed) begin
      pop_m = (q.size() != 0) && bus.out_ready;
      if (pop_m) begin
        chk("sb_data", bus.out_data, q[0]);
        void'(q.pop_front());
      end
      if (bus.in_valid) begin
        if (q.size() < DEPTH) q.push_back(bus.in_data);
        else ovf_m = 1'b1;
      end
    end
  end
  initial begin
    vecs[0]  = '{1, 32'hAB, 0, 1, 1, 32'hAB, 0, 0};
    vecs[1]  = '{0, 32'h0,  1, 0, 0, 32'h0,  0, 0};
    vecs[2]  = '{1, 32'h1,  0, 1, 1, 32'h1,  0, 0};
    vecs[3]  = '{1, 32'h2,  0, 2, 1, 32'h1,  0, 0};
    vecs[4]  = '{1, 32'h3,  0, 3, 1, 32'h1,  1, 0};
    vecs[5]  = '{1, 32'h4,  0, 4, 1, 32'h1,  1, 0};
    vecs[6]  = '{1, 32'h5,  0, 4, 1, 32'h1,  1, 1};
    vecs[7]  = '{0, 32'h0,  1, 3, 1, 32'h2,  1, 1};
    vecs[8]  = '{0, 32'h0,  1, 2, 1, 32'h3,  0, 1};
    vecs[9]  = '{0, 32'h0,  1, 1, 1, 32'h4,  0, 1};
    vecs[10] = '{0, 32'h0,  1, 0, 0, 32'h0,  0, 1};
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    chk("reset_count", 32'(bus.count), 0);
    chk("reset_out_valid", 32'(bus.out_valid), 0);
    chk("reset_almost_full", 32'(bus.almost_full), 0);
    chk("reset_overflow", 32'(bus.overflow), 0);
    foreach (vecs[i]) begin
      cycle(vecs[i].v, vecs[i].d, vecs[i].r);
      chk($sformatf("vec%0d_count", i), 32'(bus.count), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].ov));
      chk($sformatf("vec%0d_almost_full", i), 32'(bus.almost_full), 32'(vecs[i].af));
      chk($sformatf("vec%0d_overflow", i), 32'(bus.overflow), 32'(vecs[i].of));
      if (vecs[i].ov) chk($sformatf("vec%0d_head", i), bus.out_data, vecs[i].head);
    end
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cycle(1, 32'hA0 + 32'(i), 0);
    cycle(1, 32'h55, 1);
    chk("full_pushpop_count", 32'(bus.count), 4);
    chk("full_pushpop_overflow", 32'(bus.overflow), 0);
    chk("full_pushpop_head", bus.out_data, 32'hA1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1);
    chk("full_pushpop_last", bus.out_data, 32'h55);
    cycle(0, 0, 1);
    for (int i = 0; i < 100; i++) begin
      cycle(1, 32'(i), 1);
      chk("stream_data", bus.out_data, 32'(i));
      chk("stream_count_le1", 32'(bus.count <= 1), 1);
    end
    cycle(0, 0, 1);
    for (int i = 0; i < 300; i++)
      cycle(!bus.almost_full, $urandom, 1'($urandom_range(0, 1)));
    chk("random_overflow", 32'(bus.overflow), 0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 1);
    chk("random_drained", 32'(bus.count), 0);
    for (int i = 0; i < 10; i++) begin
      cycle(1, 32'h100 + 32'(i), 1);
      chk("wrap_data", bus.out_data, 32'h100 + 32'(i));
    end
    cycle(0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(1, 32'h200 + 32'(i), 0);
    chk("pre_rst_count", 32'(bus.count), 3);
    cycle(1, 32'h77, 0, 1);
    chk("mid_rst_count", 32'(bus.count), 0);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_overflow", 32'(bus.overflow), 0);
    cycle(1, 32'h99, 0);
    chk("post_rst_head", bus.out_data, 32'h99);
    chk("post_rst_out_valid", 32'(bus.out_valid), 1);
    cycle(0, 0, 1);
    cycle(0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
